// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider.
// CLKDIV_DUTY_EN: when defined, the high phase comes from a programmable
// duty value instead of ceil(N/2).
package clkdiv_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef CLKDIV_DUTY_EN
  // High phase length: the duty value, clamped to the period.
  function automatic int unsigned high_count(input int unsigned n, input int unsigned duty);
    return (duty < n) ? duty : n;
  endfunction
`else
  // High phase length: ceil(N/2).
  function automatic int unsigned high_count(input int unsigned n);
    return (n + 1) / 2;
  endfunction
`endif

endpackage

// File: rtl/clkdiv_reload_reg.sv
// Divisor reload register for prog_freq_divider.
// Accepts a new divisor over valid/ready, rejects zero with a one-cycle
// div_err pulse, and holds an accepted value as pending until the top
// raises apply (wrap edge, IDLE entry, or any edge while idle).
// CLKDIV_DUTY_EN: a duty value travels alongside the divisor.
module clkdiv_reload_reg #(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             apply,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_value,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_high,
  output logic [CNT_W-1:0] cur_duty,
  output logic [CNT_W-1:0] nxt_duty,
`endif
  output logic             div_ready,
  output logic             div_err,
  output logic [CNT_W-1:0] cur_div,
  output logic [CNT_W-1:0] nxt_div
);

  // Handshake: a transfer happens on an edge where div_valid and
  // div_ready are both high; div_value (and duty) are sampled on that edge.
  logic             accept;
  logic             good;
  logic             pend_valid;
  logic [CNT_W-1:0] pend_div;
`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0] pend_duty;
`endif

  assign accept = div_valid && div_ready;
  assign good   = accept && (div_value != '0);

  // Value cur_div takes on this edge: a fresh accept wins on an apply edge,
  // otherwise the pending value is committed.
  always_comb begin
    nxt_div = cur_div;
`ifdef CLKDIV_DUTY_EN
    nxt_duty = cur_duty;
`endif
    if (apply) begin
      if (good) begin
        nxt_div = div_value;
`ifdef CLKDIV_DUTY_EN
        nxt_duty = duty_high;
`endif
      end else if (pend_valid) begin
        nxt_div = pend_div;
`ifdef CLKDIV_DUTY_EN
        nxt_duty = pend_duty;
`endif
      end
    end
  end

  // Commit, pend, and error-pulse registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cur_div    <= CNT_W'(DIV_RESET);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      div_ready  <= 1'b1;
      div_err    <= 1'b0;
`ifdef CLKDIV_DUTY_EN
      cur_duty   <= CNT_W'((DIV_RESET + 1) / 2);
      pend_duty  <= '0;
`endif
    end else begin
      div_err <= accept && (div_value == '0);
      cur_div <= nxt_div;
`ifdef CLKDIV_DUTY_EN
      cur_duty <= nxt_duty;
`endif
      if (apply) begin
        pend_valid <= 1'b0;
        div_ready  <= 1'b1;
      end else if (good) begin
        pend_div   <= div_value;
        pend_valid <= 1'b1;
        div_ready  <= 1'b0;
`ifdef CLKDIV_DUTY_EN
        pend_duty  <= duty_high;
`endif
      end
    end
  end

endmodule

// File: rtl/prog_freq_divider.sv
// Runtime-programmable integer clock divider (top).
// Produces a registered divided waveform clk_out and a period-start tick.
// New divisors are switched only at a period boundary or on entering IDLE.
// CLKDIV_DUTY_EN: adds duty_high input; high phase = min(duty_high, N).
module prog_freq_divider
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int DIV_RESET = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             div_valid,
  input  logic [CNT_W-1:0] div_value,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] duty_high,
`endif
  output logic             div_ready,
  output logic [CNT_W-1:0] cur_div,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic [0:0]       state_dbg
);

  if (DIV_RESET == 0 || DIV_RESET >= (1 << CNT_W)) begin : g_bad_div_reset
    $error("prog_freq_divider: DIV_RESET must be in 1..2^CNT_W-1");
  end

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] nxt_div;
  logic             wrap;
  logic             apply;
  int unsigned      h_nxt;

  assign state_dbg = state;
  assign wrap      = (state == ST_RUN) && (cnt == cur_div - CNT_W'(1));
  // Divisor may change while idle, on the IDLE-entry edge, or on a wrap.
  assign apply     = (state == ST_IDLE) || !en || wrap;

`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0] cur_duty;
  logic [CNT_W-1:0] nxt_duty;
  assign h_nxt = high_count(int'(nxt_div), int'(nxt_duty));
`else
  assign h_nxt = high_count(int'(nxt_div));
`endif

  clkdiv_reload_reg #(
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RESET)
  ) u_reload (
    .clk_in    (clk_in),
    .rst       (rst),
    .apply     (apply),
    .div_valid (div_valid),
    .div_value (div_value),
`ifdef CLKDIV_DUTY_EN
    .duty_high (duty_high),
    .cur_duty  (cur_duty),
    .nxt_duty  (nxt_duty),
`endif
    .div_ready (div_ready),
    .div_err   (div_err),
    .cur_div   (cur_div),
    .nxt_div   (nxt_div)
  );

  // Counter value for the next cycle: restart on RUN entry or wrap.
  always_comb begin
    cnt_next = '0;
    if (state == ST_RUN && !wrap) cnt_next = cnt + CNT_W'(1);
  end

  // FSM, period counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!en) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= ST_RUN;
      cnt     <= cnt_next;
      tick    <= (cnt_next == '0);
      clk_out <= (int'(cnt_next) < h_nxt);
    end
  end

endmodule

// File: tb/tb_prog_freq_divider.sv
// Bench for prog_freq_divider: directed scenarios then random traffic,
// checked cycle by cycle against a period/position reference model.
module tb_prog_freq_divider;

  localparam int CNT_W     = 8;
  localparam int DIV_RESET = 2;
  localparam int W         = CNT_W + 4;

  logic             clk_in = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             div_valid = 1'b0;
  logic [CNT_W-1:0] div_value = '0;
  logic [CNT_W-1:0] duty_high = '0;
  logic             div_ready;
  logic [CNT_W-1:0] cur_div;
  logic             div_err;
  logic             clk_out;
  logic             tick;
  logic [0:0]       state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state: running flag, position in period, divisor,
  // duty, and the pending reload.
  bit          m_run;
  int unsigned m_pos, m_n, m_duty, m_pn, m_pd;
  bit          m_pv, m_err;

  always #5 clk_in = ~clk_in;

  prog_freq_divider #(.CNT_W(CNT_W), .DIV_RESET(DIV_RESET)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .div_valid (div_valid),
    .div_value (div_value),
`ifdef CLKDIV_DUTY_EN
    .duty_high (duty_high),
`endif
    .div_ready (div_ready),
    .cur_div   (cur_div),
    .div_err   (div_err),
    .clk_out   (clk_out),
    .tick      (tick),
    .state_dbg (state_dbg)
  );

  function automatic int unsigned model_high();
`ifdef CLKDIV_DUTY_EN
    return (m_duty < m_n) ? m_duty : m_n;
`else
    return (m_n + 1) / 2;
`endif
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input bit r, input bit e, input bit v,
                            input int unsigned val, input int unsigned dh);
    bit acc, good;
    if (r) begin
      m_run = 0; m_pos = 0; m_n = DIV_RESET; m_duty = (DIV_RESET + 1) / 2;
      m_pv = 0; m_pn = 0; m_pd = 0; m_err = 0;
      return;
    end
    acc   = v && !m_pv;
    m_err = acc && (val == 0);
    good  = acc && (val != 0);
    if (!m_run || !e || (m_pos + 1 >= m_n)) begin
      // Boundary: idle, leaving RUN, or end of a period.
      if (m_pv) begin m_n = m_pn; m_duty = m_pd; end
      m_pv = 0;
      if (good) begin m_n = val; m_duty = dh; end
      m_pos = 0;
      m_run = e;
    end else begin
      m_pos = m_pos + 1;
      if (good) begin m_pv = 1; m_pn = val; m_pd = dh; end
    end
  endtask

  // Drive one cycle of inputs and queue the response expected after the edge.
  task automatic step(input bit r, input bit e, input bit v,
                      input int unsigned val, input int unsigned dh);
    logic [W-1:0] exp_v;
    @(negedge clk_in);
    rst = r; en = e; div_valid = v;
    div_value = CNT_W'(val); duty_high = CNT_W'(dh);
    model_edge(r, e, v, val, dh);
    exp_v = {CNT_W'(m_n), !m_pv, m_err,
             m_run && (m_pos < model_high()), m_run && (m_pos == 0)};
    exp_q.push_back(exp_v);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  // Hold en high until the model reaches position p (bounded).
  task automatic run_to_pos(input int unsigned p);
    int guard = 0;
    while (!(m_run && m_pos == p) && guard < 300) begin
      step(0, 1, 0, 0, 0);
      guard++;
    end
    if (guard >= 300) begin
      $display("FAIL run_to_pos timeout: pos %0d, required %0d", m_pos, p);
      miscompares++;
    end
  endtask

  // Monitor: outputs are valid every cycle; compare just after each edge.
  initial begin
    logic [W-1:0] e, a;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {cur_div, div_ready, div_err, clk_out, tick};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got div=%0d rdy=%b err=%b clk=%b tick=%b, required div=%0d rdy=%b err=%b clk=%b tick=%b",
                   $time, a[W-1:4], a[3], a[2], a[1], a[0], e[W-1:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    int unsigned v;
    // 1: reset, then default divisor
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    run(8);
    // 2: load 5 while idle, then run
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 5, 2);
    run(12);
    // 3: load 3 mid-period
    run_to_pos(1);
    step(0, 1, 1, 3, 1);
    run(10);
    // 4: reject zero while running N=4
    step(0, 0, 1, 4, 2);
    run(3);
    step(0, 1, 1, 0, 0);
    run(9);
    // 5: N=1, then drop en
    step(0, 0, 1, 1, 1);
    run(5);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // 6: pending load discarded by reset
    step(0, 0, 1, 6, 3);
    run_to_pos(1);
    step(0, 1, 1, 9, 4);
    run_to_pos(3);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
`ifdef CLKDIV_DUTY_EN
    step(0, 0, 1, 4, 1);
    run(9);
    step(0, 0, 1, 5, 0);
    run(7);
    step(0, 0, 1, 3, 7);
    run(5);
`endif
    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      v = $urandom_range(0, 12);
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 15) != 0,
           $urandom_range(0, 5) == 0,
           ($urandom_range(0, 9) == 0) ? 0 : v,
           $urandom_range(0, 14));
    end
    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk_in);
    #2;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
